ram_request_controller: RTL and testbench

- Upstream front-end for the 64x8 single-port RAM block.
- Accepts write/read commands over a valid/ready handshake and sequences the RAM's address, write_data and write_enable pins.
- Captures read data from the RAM's registered-address read path and returns it over a valid/ready response channel.
- Isolates clients from the RAM's one-edge read latency and its write-xor-read behaviour.

---
 rtl/ram_request_controller_pkg.sv | 26 ++
 rtl/ram_request_controller.sv | 165 ++++++++++++++++
 tb/tb_ram_request_controller.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_request_controller_pkg.sv
// ---------------------------------------------------------------------------
// ram_request_controller_pkg
//   Shared definitions for the RAM request controller and the 64x8
//   single-port RAM it drives.
//   - RAM_ADDR_WIDTH / RAM_DATA_WIDTH : widths both blocks agree on.
//   - state_t                         : controller FSM state encoding.
//   Optional feature macro: RAM_REQUEST_CONTROLLER_CLEAR_EN adds ST_CLEAR.
// ---------------------------------------------------------------------------
package ram_request_controller_pkg;

  localparam int RAM_ADDR_WIDTH = 6;
  localparam int RAM_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WRITE        = 3'd1,
    ST_READ_ADDR    = 3'd2,
    ST_READ_CAPTURE = 3'd3,
    ST_RESP         = 3'd4
`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
    ,
    ST_CLEAR        = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/ram_request_controller.sv
// ---------------------------------------------------------------------------
// ram_request_controller
//   Front-end for a single-port RAM with a registered-address read path.
//   Accepts one write or read command at a time over cmd_valid/cmd_ready,
//   drives registered RAM pins, and returns read data over
//   rsp_valid/rsp_ready. Only one read may be outstanding.
//
//   Ports
//     clock, reset_n          : rising-edge clock, async active-low reset
//     cmd_valid/cmd_ready     : command handshake
//     cmd_write/address/data  : 1 = write, target address, write data
//     rsp_valid/ready/data    : read response channel (held until taken)
//     ram_address/write_data/write_enable : registered RAM control pins
//     ram_read_data           : RAM read data (valid one edge after address)
//     busy                    : high in every state except IDLE
//     clear_start             : (optional) start a fill sweep of the RAM
//
//   Optional feature macro: RAM_REQUEST_CONTROLLER_CLEAR_EN
//     Adds clear_start, FILL_VALUE and a CLEAR state that writes FILL_VALUE
//     to every address, one per clock, then returns to IDLE.
// ---------------------------------------------------------------------------
module ram_request_controller
  import ram_request_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
  ,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
`endif
) (
  input  logic                  clock,
  input  logic                  reset_n,
`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
  input  logic                  clear_start,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  busy
);

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_cmd_ready;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic [ADDR_WIDTH-1:0]   r_ram_address;
  logic [DATA_WIDTH-1:0]   r_ram_write_data;
  logic                    r_ram_write_enable;
  logic                    w_accept;
  logic                    w_clear_go;

`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  // A clear request in IDLE wins over a command presented on the same edge.
  assign w_clear_go = (r_state == ST_IDLE) && clear_start;
`else
  assign w_clear_go = 1'b0;
`endif

  // cmd_ready is registered, so it is 0 for the first cycle after reset
  // release even though the state is already IDLE.
  assign w_accept = cmd_valid && r_cmd_ready && !w_clear_go;

  // ---------------------------------------------------------------- state
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // ----------------------------------------------------------- next state
  // NOTE: the default assignment at the top keeps this block purely
  // combinational; without it a missed branch would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
        if (w_clear_go)    w_next_state = ST_CLEAR;
        else
`endif
        if (w_accept)      w_next_state = cmd_write ? ST_WRITE : ST_READ_ADDR;
      end
      ST_WRITE:            w_next_state = ST_IDLE;
      ST_READ_ADDR:        w_next_state = ST_READ_CAPTURE;
      ST_READ_CAPTURE:     w_next_state = ST_RESP;
      ST_RESP:             if (rsp_ready) w_next_state = ST_IDLE;
`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
      ST_CLEAR:            if (r_ram_address == LAST_ADDR) w_next_state = ST_IDLE;
`endif
      default:             w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------- datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_ready        <= 1'b0;
      r_rsp_valid        <= 1'b0;
      r_rsp_data         <= '0;
      r_ram_address      <= '0;
      r_ram_write_data   <= '0;
      r_ram_write_enable <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next_state == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
          if (w_clear_go) begin
            r_ram_address      <= '0;
            r_ram_write_data   <= FILL_VALUE;
            r_ram_write_enable <= 1'b1;
          end else
`endif
          if (w_accept) begin
            r_ram_address      <= cmd_address;
            r_ram_write_enable <= cmd_write;
            if (cmd_write) r_ram_write_data <= cmd_data;
          end
        end
        // The RAM stores the word on this edge; release the enable.
        ST_WRITE:          r_ram_write_enable <= 1'b0;
        // RAM read data now reflects the address it registered last edge.
        ST_READ_CAPTURE: begin
          r_rsp_data  <= ram_read_data;
          r_rsp_valid <= 1'b1;
        end
        ST_RESP:           if (rsp_ready) r_rsp_valid <= 1'b0;
`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
        // Counter stops on the last address instead of wrapping to 0.
        ST_CLEAR: begin
          if (r_ram_address == LAST_ADDR) r_ram_write_enable <= 1'b0;
          else                            r_ram_address      <= r_ram_address + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    cmd_ready        = r_cmd_ready;
    busy             = (r_state != ST_IDLE);
    rsp_valid        = r_rsp_valid;
    rsp_data         = r_rsp_data;
    ram_address      = r_ram_address;
    ram_write_data   = r_ram_write_data;
    ram_write_enable = r_ram_write_enable;
  end

endmodule

// File: tb/tb_ram_request_controller.sv
// ---------------------------------------------------------------------------
// tb_ram_request_controller
//   Drives ram_request_controller against a behavioural 64x8 single-port RAM
//   with a registered read address. Read expectations are queued when the
//   read is accepted and popped when the response is taken.
//   Optional feature macro: RAM_REQUEST_CONTROLLER_CLEAR_EN enables the
//   clear-sweep sequence (FILL_VALUE = 8'hA5).
// ---------------------------------------------------------------------------
module tb_ram_request_controller;
  import ram_request_controller_pkg::*;

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int DW = RAM_DATA_WIDTH;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_write_data;
  logic          ram_write_enable;
  logic [DW-1:0] ram_read_data;
  logic          busy;
`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
  logic          clear_start = 1'b0;
`endif

  always #5 clock = ~clock;

  ram_request_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
    ,
    .FILL_VALUE (8'hA5)
`endif
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
    .clear_start      (clear_start),
`endif
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_address      (cmd_address),
    .cmd_data         (cmd_data),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .ram_write_enable (ram_write_enable),
    .ram_read_data    (ram_read_data),
    .busy             (busy)
  );

  // Single-port RAM: write on the edge, read from the registered address.
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] ram_addr_q;
  always @(posedge clock) begin
    if (ram_write_enable) mem[ram_address] <= ram_write_data;
    ram_addr_q <= ram_address;
  end
  assign ram_read_data = mem[ram_addr_q];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q [$];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vec [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits for cmd_ready, presents one command for its accept edge and
  // returns just after that edge. Reads queue their expected data.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp, output int acc);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_write   = w;
    cmd_address = a;
    cmd_data    = d;
    @(posedge clock);
    #1;
    acc       = cyc;
    cmd_valid = 1'b0;
    if (!w) exp_q.push_back(exp);
  endtask

  // Waits for a response, compares it with the scoreboard head, takes it.
  task automatic get_rsp(input string name);
    int n = 0;
    logic [DW-1:0] e;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({name, "_valid"}, rsp_valid, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check(name, rsp_data, e);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    check({name, "_drop"}, rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int acc, prev, bad;
    logic prev_wr;

    vec[0]  = '{1'b1, 6'd0,  8'h10, 8'h00};
    vec[1]  = '{1'b1, 6'd1,  8'h11, 8'h00};
    vec[2]  = '{1'b1, 6'd2,  8'h12, 8'h00};
    vec[3]  = '{1'b1, 6'd3,  8'h13, 8'h00};
    vec[4]  = '{1'b0, 6'd0,  8'h00, 8'h10};
    vec[5]  = '{1'b0, 6'd1,  8'h00, 8'h11};
    vec[6]  = '{1'b0, 6'd2,  8'h00, 8'h12};
    vec[7]  = '{1'b0, 6'd3,  8'h00, 8'h13};
    vec[8]  = '{1'b1, 6'd63, 8'hFF, 8'h00};
    vec[9]  = '{1'b1, 6'd62, 8'h00, 8'h00};
    vec[10] = '{1'b0, 6'd63, 8'h00, 8'hFF};
    vec[11] = '{1'b0, 6'd62, 8'h00, 8'h00};
    vec[12] = '{1'b1, 6'd0,  8'hC3, 8'h00};
    vec[13] = '{1'b0, 6'd0,  8'h00, 8'hC3};

    // ---- reset values
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_we", ram_write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", ram_address, 0);
    check("rst_wdata", ram_write_data, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rel_cmd_ready_pre", cmd_ready, 0);
    @(posedge clock);
    #1;
    check("rel_cmd_ready", cmd_ready, 1);

    // ---- single write: enable for exactly one cycle
    issue(1'b1, 6'd9, 8'd9, 8'd0, acc);
    check("wr9_we", ram_write_enable, 1);
    check("wr9_addr", ram_address, 9);
    check("wr9_wdata", ram_write_data, 9);
    check("wr9_cmd_ready", cmd_ready, 0);
    check("wr9_busy", busy, 1);
    @(posedge clock);
    #1;
    check("wr9_we_drop", ram_write_enable, 0);
    check("wr9_cmd_ready_back", cmd_ready, 1);
    check("wr9_addr_hold", ram_address, 9);

    // ---- read latency: rsp_valid on the third edge counting the accept edge
    issue(1'b1, 6'd27, 8'd27, 8'd0, acc);
    issue(1'b0, 6'd27, 8'd0, 8'd27, acc);
    check("rd27_e1", rsp_valid, 0);
    @(posedge clock);
    #1;
    check("rd27_e2", rsp_valid, 0);
    @(posedge clock);
    #1;
    check("rd27_e3", rsp_valid, 1);
    get_rsp("rd27");

    // ---- response held while the consumer stalls
    issue(1'b1, 6'd21, 8'h5A, 8'd0, acc);
    issue(1'b0, 6'd21, 8'd0, 8'h5A, acc);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || cmd_ready !== 1'b0) bad++;
      @(posedge clock);
      #1;
    end
    check("rd21_hold", bad, 0);
    get_rsp("rd21");
    check("rd21_cmd_ready", cmd_ready, 1);
    check("rd21_busy", busy, 0);

    // ---- table: back-to-back writes, in-order reads, boundary addresses
    prev    = 0;
    prev_wr = 1'b0;
    for (int i = 0; i < 14; i++) begin
      issue(vec[i].wr, vec[i].addr, vec[i].data, vec[i].exp, acc);
      if (vec[i].wr && prev_wr) check($sformatf("vec%0d_wr_rate", i), acc - prev, 2);
      prev    = acc;
      prev_wr = vec[i].wr;
      if (!vec[i].wr) get_rsp($sformatf("vec%0d", i));
    end

    // ---- reset during READ_CAPTURE discards the response
    issue(1'b0, 6'd1, 8'd0, 8'h11, acc);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("rstrd_rsp_valid", rsp_valid, 0);
    check("rstrd_busy", busy, 0);
    check("rstrd_cmd_ready", cmd_ready, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rstrd_cmd_ready_pre", cmd_ready, 0);
    @(posedge clock);
    #1;
    check("rstrd_cmd_ready_post", cmd_ready, 1);
    check("rstrd_rsp_valid_post", rsp_valid, 0);

    // ---- reset during WRITE: the word must not be stored
    issue(1'b1, 6'd5, 8'h11, 8'd0, acc);
    issue(1'b1, 6'd5, 8'h77, 8'd0, acc);
    check("rstwr_we", ram_write_enable, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstwr_we_drop", ram_write_enable, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    issue(1'b0, 6'd5, 8'd0, 8'h11, acc);
    get_rsp("rstwr_rd5");

`ifdef RAM_REQUEST_CONTROLLER_CLEAR_EN
    // ---- clear sweep beats a simultaneous command
    @(negedge clock);
    clear_start = 1'b1;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b1;
    cmd_address = 6'd7;
    cmd_data    = 8'h33;
    @(posedge clock);
    #1;
    clear_start = 1'b0;
    check("clr_start_busy", busy, 1);
    check("clr_start_we", ram_write_enable, 1);
    check("clr_start_addr", ram_address, 0);
    check("clr_start_wdata", ram_write_data, 8'hA5);
    bad = 0;
    acc = 0;
    while (busy === 1'b1 && acc < 200) begin
      acc++;
      if (cmd_ready !== 1'b0 || ram_write_enable !== 1'b1) bad++;
      @(posedge clock);
      #1;
    end
    check("clr_cycles", acc, 64);
    check("clr_hold", bad, 0);
    check("clr_end_addr", ram_address, 63);
    check("clr_end_we", ram_write_enable, 0);
    check("clr_end_cmd_ready", cmd_ready, 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    check("clr_cmd_we", ram_write_enable, 1);
    check("clr_cmd_addr", ram_address, 7);
    issue(1'b0, 6'd0, 8'd0, 8'hA5, acc);
    get_rsp("clr_rd0");
    issue(1'b0, 6'd63, 8'd0, 8'hA5, acc);
    get_rsp("clr_rd63");
    issue(1'b0, 6'd7, 8'd0, 8'h33, acc);
    get_rsp("clr_rd7");
    issue(1'b0, 6'd30, 8'd0, 8'hA5, acc);
    get_rsp("clr_rd30");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
